// File: rtl/wb_gpio_irq.sv
// Wishbone byte-wide GPIO with per-pin edge interrupts, sticky W1C status.
// Ports: wb_* slave bus, gpio_i/gpio_o/gpio_dir_o pins, irq_o level irq.
module wb_gpio_irq #(
  parameter int GPIO_WIDTH   = 32,
  parameter int WB_ADR_WIDTH = 5,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET = '0,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
  input  logic [7:0]              wb_dat_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic [7:0]              wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  input  logic [GPIO_WIDTH-1:0]   gpio_i,
  output logic [GPIO_WIDTH-1:0]   gpio_o,
  output logic [GPIO_WIDTH-1:0]   gpio_dir_o,
  output logic                    irq_o
);

  localparam int NB = GPIO_WIDTH / 8;
  localparam int AW = WB_ADR_WIDTH;

  logic [GPIO_WIDTH-1:0] r_s1, r_s2, r_p;
  logic [GPIO_WIDTH-1:0] r_out, r_dir, r_ien, r_ipol, r_istat;
  logic [1:0]            r_arm;
  logic                  r_ack, r_irq;
  logic [7:0]            r_dat;

  logic                  w_req, w_wr;
  logic [7:0]            w_rdat;
  logic [GPIO_WIDTH-1:0] w_out_n, w_dir_n, w_ien_n, w_ipol_n;
  logic [GPIO_WIDTH-1:0] w_clr, w_rise, w_fall, w_set, w_istat_n;
  logic                  w_unused_ok;

  assign w_unused_ok = ^{wb_cti_i, wb_bte_i};

  assign wb_dat_o   = r_dat;
  assign wb_ack_o   = r_ack;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign gpio_o     = r_out;
  assign gpio_dir_o = r_dir;
  assign irq_o      = r_irq;

  // Holding off a request while ack is high gives one access per 2 cycles.
  assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr  = w_req & wb_we_i;

  always_comb begin
    w_rdat   = 8'h00;
    w_out_n  = r_out;
    w_dir_n  = r_dir;
    w_ien_n  = r_ien;
    w_ipol_n = r_ipol;
    w_clr    = '0;
    for (int k = 0; k < NB; k++) begin
      if (wb_adr_i == AW'(k)) begin
        w_rdat = r_s2[8*k +: 8];
        if (w_wr) w_out_n[8*k +: 8] = wb_dat_i;
      end
      if (wb_adr_i == AW'(NB + k)) begin
        w_rdat = r_dir[8*k +: 8];
        if (w_wr) w_dir_n[8*k +: 8] = wb_dat_i;
      end
      if (wb_adr_i == AW'(2*NB + k)) begin
        w_rdat = r_ien[8*k +: 8];
        if (w_wr) w_ien_n[8*k +: 8] = wb_dat_i;
      end
      if (wb_adr_i == AW'(3*NB + k)) begin
        w_rdat = r_ipol[8*k +: 8];
        if (w_wr) w_ipol_n[8*k +: 8] = wb_dat_i;
      end
      if (wb_adr_i == AW'(4*NB + k)) begin
        w_rdat = r_istat[8*k +: 8];
        if (w_wr) w_clr[8*k +: 8] = wb_dat_i;
      end
    end
  end

  // Edges are ignored until the synchroniser and p have primed after reset.
  assign w_rise    = r_s2 & ~r_p;
  assign w_fall    = ~r_s2 & r_p;
  assign w_set     = (r_arm == 2'd3)
                   ? ((w_rise & r_ipol) | (w_fall & ~r_ipol))
                   : '0;
  // New status overrides a clear landing on the same bit.
  assign w_istat_n = (r_istat & ~w_clr) | w_set;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_p     <= '0;
      r_arm   <= 2'd0;
      r_out   <= OUT_RESET;
      r_dir   <= DIR_RESET;
      r_ien   <= '0;
      r_ipol  <= '0;
      r_istat <= '0;
      r_ack   <= 1'b0;
      r_dat   <= 8'h00;
      r_irq   <= 1'b0;
    end else begin
      r_s1    <= gpio_i;
      r_s2    <= r_s1;
      r_p     <= r_s2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
      r_out   <= w_out_n;
      r_dir   <= w_dir_n;
      r_ien   <= w_ien_n;
      r_ipol  <= w_ipol_n;
      r_istat <= w_istat_n;
      r_ack   <= w_req;
      if (w_req) r_dat <= w_rdat;
      r_irq   <= |(r_istat & r_ien);
    end
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq (GPIO_WIDTH=32).
// Bus tasks queue expectations; a negedge monitor checks every ack.
module tb_wb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  adr;
  logic [7:0]  dat_i;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [7:0]  dat_o;
  logic        ack, err, rty;
  logic [31:0] gpio_i, gpio_o, gpio_dir;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rd;
    logic [7:0] d;
    string      nm;
  } exp_t;

  exp_t sb[$];
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;

  wb_gpio_irq #(
    .GPIO_WIDTH(32),
    .WB_ADR_WIDTH(5),
    .DIR_RESET(32'h0),
    .OUT_RESET(32'h0)
  ) dut (
    .wb_clk    (clk),
    .wb_rst_n  (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_rty_o  (rty),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_dir_o(gpio_dir),
    .irq_o     (irq)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every ack must be 1 cycle wide and match a queued entry.
  always @(negedge clk) begin
    if (ack) begin
      exp_t e;
      checks++;
      if (prev_ack) begin
        failures++;
        $display("FAIL ack_width: got 2+ cycles expected 1");
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: got ack expected none");
      end else begin
        e = sb.pop_front();
        if (e.rd) begin
          checks++;
          if (dat_o !== e.d) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     e.nm, dat_o, e.d);
          end
        end
      end
    end
    prev_ack = ack;
  end

  // Starts from a negedge; returns at the negedge after the ack edge.
  task automatic xfer(logic w, logic [4:0] a, logic [7:0] d,
                      logic [7:0] exp, string nm);
    exp_t e;
    @(negedge clk);
    adr = a; dat_i = d; we = w; cyc = 1'b1; stb = 1'b1;
    e.rd = ~w; e.d = exp; e.nm = nm;
    sb.push_back(e);
    chk({nm, "_no_early_ack"}, 64'(ack), 64'd0);
    @(negedge clk);
    chk({nm, "_ack"}, 64'(ack), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(logic [4:0] a, logic [7:0] d);
    xfer(1'b1, a, d, 8'h00, "wr");
  endtask

  task automatic rd(logic [4:0] a, logic [7:0] exp, string nm);
    xfer(1'b0, a, 8'h00, exp, nm);
  endtask

  initial begin
    rst_n = 1'b0; adr = '0; dat_i = '0; we = 0; cyc = 0; stb = 0;
    cti = 3'b000; bte = 2'b00;
    gpio_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst_gpio_o", 64'(gpio_o), 64'h0);
    chk("rst_dir", 64'(gpio_dir), 64'h0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'h0);
    chk("rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;

    // Priming with all inputs high must not record edges.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("prime_irq", 64'(irq), 64'd0);
    end
    for (int k = 0; k < 4; k++) rd(5'(16 + k), 8'h00, "prime_istat");

    // Falling edges with IPOL=0 set status on every pin.
    gpio_i = 32'h0;
    repeat (4) @(negedge clk);
    rd(5'd16, 8'hFF, "fall_all_istat0");
    rd(5'd19, 8'hFF, "fall_all_istat3");
    chk("fall_all_irq_masked", 64'(irq), 64'd0);
    for (int k = 0; k < 4; k++) wr(5'(16 + k), 8'hFF);
    for (int k = 0; k < 4; k++) rd(5'(16 + k), 8'h00, "w1c_all");

    // Output and direction byte writes.
    wr(5'd1, 8'hA5);
    chk("gpio_o_byte1", 64'(gpio_o), 64'h0000_A500);
    wr(5'd5, 8'hFF);
    chk("dir_byte1", 64'(gpio_dir), 64'h0000_FF00);
    rd(5'd5, 8'hFF, "dir_rd");

    // Rising edge on pin 0 with interrupt enabled.
    wr(5'd8, 8'h01);
    wr(5'd12, 8'h01);
    gpio_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("irq_before_lat", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_at_lat", 64'(irq), 64'd1);
    rd(5'd0, 8'h01, "data_rd");
    rd(5'd16, 8'h01, "rise_istat");
    wr(5'd16, 8'h01);
    chk("irq_ack_cycle", 64'(irq), 64'd1);
    @(negedge clk);
    chk("irq_cleared", 64'(irq), 64'd0);

    // Falling edge on pin 3, masked, then unmasked.
    gpio_i[3] = 1'b1;
    repeat (4) @(negedge clk);
    rd(5'd16, 8'h00, "rise_ignored_ipol0");
    gpio_i[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd(5'd16, 8'h08, "fall_istat");
    chk("fall_irq_masked", 64'(irq), 64'd0);
    wr(5'd8, 8'h09);
    chk("ien_ack_cycle_irq", 64'(irq), 64'd0);
    @(negedge clk);
    chk("ien_irq", 64'(irq), 64'd1);

    // Status set coinciding with its W1C clear.
    gpio_i[3] = 1'b1;
    repeat (4) @(negedge clk);
    wr(5'd16, 8'h08);
    rd(5'd16, 8'h00, "pre_race_clear");
    gpio_i[3] = 1'b0;
    @(negedge clk);
    wr(5'd16, 8'h08);
    rd(5'd16, 8'h08, "set_wins");
    chk("set_wins_irq", 64'(irq), 64'd1);

    // Out-of-range accesses.
    rd(5'd20, 8'h00, "oob_rd20");
    wr(5'd20, 8'hFF);
    rd(5'd31, 8'h00, "oob_rd31");
    chk("oob_gpio_o", 64'(gpio_o), 64'h0000_A500);
    chk("oob_dir", 64'(gpio_dir), 64'h0000_FF00);
    rd(5'd8, 8'h09, "oob_ien");
    rd(5'd12, 8'h01, "oob_ipol");
    rd(5'd16, 8'h08, "oob_istat");

    // Reset during a request aborts it.
    @(negedge clk);
    adr = 5'd0; dat_i = 8'h5A; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ack", 64'(ack), 64'd0);
    chk("midrst_gpio_o", 64'(gpio_o), 64'h0);
    chk("midrst_dir", 64'(gpio_dir), 64'h0);
    chk("midrst_irq", 64'(irq), 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
